// File: rtl/sample_serializer.sv
// Serial sample transmitter: frame sync bit, MSB-first data bits, generated bit clock.
// Optional even-parity bit after the LSB when SERIALIZER_PARITY_EN is defined.
`timescale 1ns/1ps
module sample_serializer #(
   parameter int D_WIDTH = 8,
   parameter int CLK_DIV = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [D_WIDTH-1:0] sample_in,
   input  logic               sample_valid,
   output logic               sample_ready,
   output logic               sdata,
   output logic               sclk,
   output logic               fsync,
   output logic               busy
);

   localparam int DW = $clog2(CLK_DIV);
   localparam int BW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SYNC,
      S_SHIFT
`ifdef SERIALIZER_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [DW-1:0]      r_div, w_div_nxt;
   logic [BW-1:0]      r_bit, w_bit_nxt;
   logic [D_WIDTH-1:0] r_shift, w_shift_nxt;
   logic               r_sdata, r_sclk, r_fsync;
   logic               w_sdata_nxt, w_sclk_nxt, w_fsync_nxt;
   logic               w_wrap;
`ifdef SERIALIZER_PARITY_EN
   logic               r_par, w_par_nxt;
`endif

   assign sample_ready = en && (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE);
   assign sdata        = r_sdata;
   assign sclk         = r_sclk;
   assign fsync        = r_fsync;
   assign w_wrap       = (r_div == DW'(CLK_DIV - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_div_nxt   = r_div;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
`ifdef SERIALIZER_PARITY_EN
      w_par_nxt   = r_par;
`endif
      if (r_state != S_IDLE)
         w_div_nxt = w_wrap ? '0 : r_div + DW'(1);
      case (r_state)
         S_IDLE: begin
            if (sample_valid) begin
               w_state_nxt = S_SYNC;
               w_div_nxt   = '0;
               w_bit_nxt   = '0;
               w_shift_nxt = sample_in;
`ifdef SERIALIZER_PARITY_EN
               w_par_nxt   = ^sample_in;
`endif
            end
         end
         S_SYNC: begin
            if (w_wrap) w_state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            if (w_wrap) begin
               w_shift_nxt = r_shift << 1;
               w_bit_nxt   = r_bit + BW'(1);
               if (r_bit == BW'(D_WIDTH - 1)) begin
                  w_bit_nxt = '0;
`ifdef SERIALIZER_PARITY_EN
                  w_state_nxt = S_PARITY;
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end
         end
`ifdef SERIALIZER_PARITY_EN
         S_PARITY: begin
            if (w_wrap) w_state_nxt = S_IDLE;
         end
`endif
         default: w_state_nxt = S_IDLE;
      endcase

      // Outputs are registered from next-state values so they line up with the state they describe.
      w_fsync_nxt = (w_state_nxt == S_SYNC);
      w_sclk_nxt  = (w_state_nxt != S_IDLE) && (w_div_nxt >= DW'(CLK_DIV / 2));
      w_sdata_nxt = 1'b0;
      if (w_state_nxt == S_SHIFT) w_sdata_nxt = w_shift_nxt[D_WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
      if (w_state_nxt == S_PARITY) w_sdata_nxt = w_par_nxt;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_div   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_sdata <= 1'b0;
         r_sclk  <= 1'b0;
         r_fsync <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else if (en) begin
         r_state <= w_state_nxt;
         r_div   <= w_div_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_sdata <= w_sdata_nxt;
         r_sclk  <= w_sclk_nxt;
         r_fsync <= w_fsync_nxt;
`ifdef SERIALIZER_PARITY_EN
         r_par   <= w_par_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_sample_serializer.sv
// Self-checking bench for sample_serializer: CLK_DIV=4 and CLK_DIV=3 instances against a per-cycle frame model.
`timescale 1ns/1ps
module tb_sample_serializer;

`ifdef SERIALIZER_PARITY_EN
   localparam int NBITS = 10;
`else
   localparam int NBITS = 9;
`endif
   localparam int IDLE_W = 16;   // {ready,busy,fsync,sclk,sdata} = 1,0,0,0,0

   logic       clk = 1'b0;
   logic       rst, en;
   logic [7:0] in_a, in_b;
   logic       val_a, val_b;
   logic       rdy_a, sd_a, sc_a, fs_a, bz_a;
   logic       rdy_b, sd_b, sc_b, fs_b, bz_b;

   int  n_chk = 0;
   int  n_err = 0;
   time t_xfer;

   always #5 clk = ~clk;

   sample_serializer #(.D_WIDTH(8), .CLK_DIV(4)) dut_a (
      .clk(clk), .rst(rst), .en(en), .sample_in(in_a), .sample_valid(val_a),
      .sample_ready(rdy_a), .sdata(sd_a), .sclk(sc_a), .fsync(fs_a), .busy(bz_a));

   sample_serializer #(.D_WIDTH(8), .CLK_DIV(3)) dut_b (
      .clk(clk), .rst(rst), .en(en), .sample_in(in_b), .sample_valid(val_b),
      .sample_ready(rdy_b), .sdata(sd_b), .sclk(sc_b), .fsync(fs_b), .busy(bz_b));

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", tag, got[4:0], exp[4:0]);
      end
   endtask

   function automatic int obs(input bit selb);
      if (selb) return int'({rdy_b, bz_b, fs_b, sc_b, sd_b});
      return int'({rdy_a, bz_a, fs_a, sc_a, sd_a});
   endfunction

   // Expected outputs in frame cycle k (k=0 is the first cycle after the transfer edge).
   function automatic int exp_word(input logic [7:0] s, input int k, input int cdiv);
      int bitp, ph, fs, sc, sd;
      bitp = k / cdiv;
      ph   = k % cdiv;
      sc   = (ph >= cdiv / 2) ? 1 : 0;
      fs   = (bitp == 0) ? 1 : 0;
      if (bitp == 0)      sd = 0;
      else if (bitp <= 8) sd = int'(s[8 - bitp]);
      else                sd = int'(^s);
      return 8 + fs * 4 + sc * 2 + sd;
   endfunction

   task automatic set_in(input bit selb, input logic [7:0] s, input logic v);
      if (selb) begin in_b = s; val_b = v; end
      else      begin in_a = s; val_a = v; end
   endtask

   // Called at a negedge. Transfers s, checks every frame cycle, optional en freeze after cycle frz_at.
   task automatic run_frame(input bit selb, input logic [7:0] s, input logic [7:0] nxt,
                            input bit hold, input int frz_at, input int frz_len);
      int cdiv, f;
      cdiv = selb ? 3 : 4;
      f    = NBITS * cdiv;
      set_in(selb, s, 1'b1);
      check("ready_before_xfer", obs(selb), IDLE_W);
      @(posedge clk);
      t_xfer = $time;
      @(negedge clk);
      for (int k = 0; k < f; k++) begin
         if (k > 0) @(negedge clk);
         if (hold) set_in(selb, nxt, 1'b1);
         else      set_in(selb, 8'($urandom), 1'b0);
         check($sformatf("frame s=%h k=%0d", s, k), obs(selb), exp_word(s, k, cdiv));
         if (k == frz_at) begin
            en = 1'b0;
            for (int j = 0; j < frz_len; j++) begin
               @(negedge clk);
               check($sformatf("freeze s=%h k=%0d j=%0d", s, k, j), obs(selb), exp_word(s, k, cdiv));
            end
            en = 1'b1;
         end
      end
      @(negedge clk);
      check($sformatf("idle_after s=%h", s), obs(selb), IDLE_W);
   endtask

   initial begin
      time t1;
      logic [7:0] rs, rn;
      rst = 1'b1; en = 1'b1;
      set_in(0, 8'h00, 1'b0);
      set_in(1, 8'h00, 1'b0);
      #2;
      check("reset_a", obs(0), IDLE_W);
      check("reset_b", obs(1), IDLE_W);
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      #1 check("ready_en_low", obs(0), 0);
      en  = 1'b1;
      @(negedge clk);

      // basic frame
      run_frame(0, 8'hA5, 8'h00, 0, -1, 0);

      // back-to-back with valid held
      run_frame(0, 8'h01, 8'h80, 1, -1, 0);
      t1 = t_xfer;
      run_frame(0, 8'h80, 8'h00, 0, -1, 0);
      check("b2b_spacing", int'((t_xfer - t1) / 10), NBITS * 4 + 1);

      // parity-relevant pair
      run_frame(0, 8'h07, 8'hA5, 1, -1, 0);
      run_frame(0, 8'hA5, 8'h00, 0, -1, 0);

      // en freeze for 5 cycles in the middle of bit 3
      run_frame(0, 8'hA5, 8'h00, 0, (1 + 3) * 4 + 1, 5);

      // asynchronous reset mid-SHIFT
      set_in(0, 8'hA5, 1'b1);
      @(posedge clk);
      @(negedge clk);
      set_in(0, 8'h3C, 1'b0);
      repeat (10) @(negedge clk);
      check("pre_reset_shift", obs(0), exp_word(8'hA5, 10, 4));
      #1 rst = 1'b1;
      #1 check("reset_async", obs(0), IDLE_W);
      @(posedge clk);
      #1 check("reset_held", obs(0), IDLE_W);
      @(negedge clk);
      rst = 1'b0;
      #1 check("reset_release", obs(0), IDLE_W);
      @(negedge clk);
      run_frame(0, 8'hFF, 8'h00, 0, -1, 0);

      // randomized frames, freezes and back-to-back pairs
      for (int i = 0; i < 6; i++) begin
         rs = 8'($urandom);
         rn = 8'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            run_frame(0, rs, rn, 1, -1, 0);
            t1 = t_xfer;
            run_frame(0, rn, 8'h00, 0, $urandom_range(0, NBITS * 4 - 1), $urandom_range(1, 4));
         end else begin
            run_frame(0, rs, 8'h00, 0, $urandom_range(0, NBITS * 4 - 1), $urandom_range(1, 4));
         end
      end

      // odd divider instance
      run_frame(1, 8'h80, 8'h00, 0, -1, 0);
      for (int i = 0; i < 4; i++) begin
         rs = 8'($urandom);
         run_frame(1, rs, 8'h00, 0, (i == 1) ? $urandom_range(0, NBITS * 3 - 1) : -1, 3);
      end
      check("a_idle_end", obs(0), IDLE_W);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sample_serializer.md
# sample_serializer

Transmit-side serializer for the audio sample path. It accepts one parallel sample at a time over a valid/ready handshake, typically the output of the delay line. It shifts each sample out MSB-first on a single serial data line, with a generated bit clock and a one-bit-period frame sync. It is the outbound counterpart to the sample-capture path and drives an external serial DAC or a loopback link.

## Interface
Parameters:
- D_WIDTH, 8, sample width in bits (≥1)
- CLK_DIV, 4, clk cycles per serial bit period (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  global enable; low freezes all state
- sample_in  in  D_WIDTH  parallel sample to transmit
- sample_valid  in  1  sample_in is valid
- sample_ready  out  1  block can accept a sample; combinational: en && state==IDLE
- sdata  out  1  serial data, registered
- sclk  out  1  serial bit clock, registered
- fsync  out  1  frame sync, high for the whole SYNC bit period, registered
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE → SYNC → SHIFT → (PARITY) → IDLE.
- IDLE:
  - Transfer occurs on the edge where sample_valid && sample_ready.
  - On transfer, latch sample_in into the shift register, clear the bit-period counter `div` and the bit index, and go to SYNC.
  - sample_valid with ready low is ignored; the source must hold the sample.
- SYNC: one bit period. fsync=1, sdata=0.
- SHIFT:
  - D_WIDTH bit periods. sdata = shift_reg[D_WIDTH-1].
  - At the end of each period, shift left by one.
  - After bit D_WIDTH-1, go to PARITY if compiled in, else IDLE.
- PARITY (optional): one bit period. sdata = XOR of the latched sample (even parity).
- Bit period:
  - `div` counts 0..CLK_DIV-1 and wraps; the state/bit advances on the wrap.
  - sclk = (div ≥ CLK_DIV/2), integer division. So sclk is low in the first half of each period, and high in the second half plus the extra cycle when CLK_DIV is odd.
  - sdata changes only at period start, which gives the receiver a rising sclk mid-bit.
- In IDLE: sclk=0, sdata=0, fsync=0.
- sample_in changes after the transfer have no effect on the frame in flight.
- en low: `div`, state, shift register and all registered outputs hold; sample_ready=0. Resuming en continues exactly where the block stopped.
- Reset (any time, including mid-frame): immediately state=IDLE, div=0, sdata=0, sclk=0, fsync=0, busy=0, shift register cleared. sample_ready is then equal to en.

## Timing
- Transfer on edge T; SYNC outputs are visible from T+1.
- Frame length F = (1 + D_WIDTH [+1 with parity]) × CLK_DIV cycles, covering cycles T+1 … T+F.
- IDLE is entered at edge T+F and sample_ready rises in cycle T+F+1.
- Earliest next transfer is at edge T+F+1. The maximum sample rate is therefore one per F+1 cycles.
- Bit n of SHIFT (n=0 is the MSB) occupies cycles T+1+(n+1)·CLK_DIV … T+(n+2)·CLK_DIV.
- busy is high for exactly cycles T+1 … T+F, excluding cycles frozen by en low, which extend the frame.

## Configuration
- SERIALIZER_PARITY_EN defined:
  - PARITY state is compiled in, F includes one extra bit period, and an even-parity bit follows the LSB.
- Undefined:
  - no PARITY state or parity logic; SHIFT returns directly to IDLE.

## Test plan
- Basic frame (D_WIDTH=8, CLK_DIV=4, no parity): send 0xA5.
  - fsync high for 4 cycles.
  - sdata sequence 1,0,1,0,0,1,0,1, each bit for 4 cycles.
  - sclk pattern 0,0,1,1 per bit.
  - busy high for 36 cycles; sample_ready returns on cycle 37.
- Back-to-back: hold sample_valid with 0x01 then 0x80.
  - Second transfer occurs exactly 37 cycles after the first.
  - Second frame's first SHIFT bit is 1; first frame's last SHIFT bit is 1.
- Parity build (SERIALIZER_PARITY_EN): send 0x07, then 0xA5.
  - Parity bits are 1 and 0.
  - Frame length is 40 cycles, with sample_ready returning on cycle 41.
- en freeze: drop en for 5 cycles during bit 3 of 0xA5.
  - All outputs hold, sample_ready=0.
  - Frame completes 5 cycles late with an unchanged bit sequence.
- Reset mid-frame: assert rst asynchronously during SHIFT, between clock edges.
  - sdata, sclk, fsync and busy go to 0 without waiting for a clock edge.
  - After release with en=1, sample_ready=1 and a fresh 0xFF frame transmits correctly.
- Odd divider (CLK_DIV=3): send 0x80.
  - sclk pattern is 0,1,1 per bit; sdata is 1 for 3 cycles, then 0.
  - Changing sample_in during the frame has no effect.
